status_register: RTL
====================

// Module: status_register
// PURPOSE
//  6502 processor status register (P): N V 1 B D I Z C. It captures the
//  flags the ALU produces, executes SEx/CLx/CLV flag ops, loads P from a
//  pulled stack byte (PLP/RTI) and forms the byte pushed by PHP/BRK/IRQ.
//  It feeds carry/overflow back to the ALU carryIn/overflowIn inputs and
//  drives a delayed IRQ mask to the interrupt logic. It sits between the
//  control unit, the ALU and the stack datapath.
// PARAMETERS
//  RESET_P    8'h24  stored P after reset (bit5 reads 1, B reads 0; I=1)
//  IRQ_DELAY  1      instruction boundaries between an I change and irq_mask (0..2)
// PORTS
//  clk         in   1  system clock; all state changes on rising edge
//  rst         in   1  synchronous, active-high reset
//  alu_n       in   1  ALU negative flag
//  alu_v       in   1  ALU overflow flag
//  alu_z       in   1  ALU zero flag
//  alu_c       in   1  ALU carry flag
//  ld_nz       in   1  capture alu_n/alu_z into N/Z this cycle
//  ld_c        in   1  capture alu_c into C
//  ld_v        in   1  capture alu_v into V
//  flag_op     in   3  0 none,1 CLC,2 SEC,3 CLI,4 SEI,5 CLD,6 SED,7 CLV
//  pull_ld     in   1  load P from pull_data (PLP/RTI)
//  pull_data   in   8  byte pulled from stack
//  set_i       in   1  force I=1 (interrupt/BRK entry)
//  push_brk    in   1  B value inserted into push_byte (1 PHP/BRK, 0 IRQ/NMI)
//  instr_done  in   1  one-cycle strobe at each instruction boundary
//  p           out  8  {N,V,1,0,D,I,Z,C} registered status
//  push_byte   out  8  {N,V,1,push_brk,D,I,Z,C}; combinational
//  carry       out  1  = p[0], to ALU carryIn
//  overflow    out  1  = p[6], to ALU overflowIn
//  decimal     out  1  = p[3]
//  irq_mask    out  1  I as seen by IRQ recognition, delayed per IRQ_DELAY
// BEHAVIOUR
//  - Reset: stored P <= RESET_P; irq_mask and all delay stages <= RESET_P[2].
//    rst overrides every other input in the same cycle.
//  - Update priority per bit, highest first: rst > pull_ld > set_i (I only) >
//    flag_op > ld_*. Bits not touched by a higher source take the lower one.
//    Untouched bits hold their value.
//  - pull_ld: N,V,D,I,Z,C <= pull_data[7,6,3,2,1,0]. Bits 5/4 are ignored;
//    p[5] always reads 1 and p[4] always reads 0.
//  - flag_op and ld_* on different bits in the same cycle: both apply
//    (e.g. CLC with ld_nz updates C, N and Z).
//  - Latency: one cycle from input to p/carry/overflow. push_byte reflects the
//    current registered P with no latency.
//  - IRQ mask pipeline: a shift register of IRQ_DELAY stages advances only on
//    instr_done.
//      stage0 <= I (registered value at the strobe); irq_mask = last stage.
//      IRQ_DELAY=0: irq_mask = I directly.
//      Default (IRQ_DELAY=1): the instruction after CLI/SEI/PLP still runs
//      under the old mask.
//    If instr_done coincides with an I write, the stage samples the pre-write I.
//  - instr_done stuck high advances the pipeline every cycle. No wrap or
//    overflow state exists.
// CONFIGURATION
//  DECIMAL_MODE_EN defined: D is a stored flag, writable by CLD/SED/pull_ld;
//    decimal = D.
//  DECIMAL_MODE_EN undefined: D storage removed. p[3], push_byte[3] and
//    decimal read 0. SED/CLD are no-ops; pull_data[3] is ignored.
// TESTING
//  1 rst=1 one cycle -> p=8'h24, irq_mask=1, carry=0, overflow=0.
//  2 ld_nz,ld_c,ld_v with alu n/v/z/c=1,1,0,1 -> next cycle p=8'hE5;
//    push_brk=1 gives push_byte=8'hF5.
//  3 CLI (op 3) then instr_done pulses -> p[2]=0 next cycle; irq_mask stays
//    1 after the 1st strobe and goes 0 after the 2nd strobe.
//  4 pull_ld, pull_data=8'hFF, same cycle as flag_op=CLC -> p=8'hEF
//    (8'hE7 without DECIMAL_MODE_EN). pull wins; B reads 0.
//  5 SEC + ld_nz (alu_n=0, alu_z=1) same cycle -> C=1, Z=1, N=0.
//    Then set_i with CLI -> I=1.
//  6 rst asserted mid-CLI pipeline (stage0=0) -> irq_mask=1 and p=8'h24
//    next cycle.

Source files
------------

// File: rtl/status_register.sv
`default_nettype none
// ============================================================================
//  Module      : status_register
//  Description : 6502 processor status register (P = N V 1 B D I Z C).
//                Captures ALU flags, executes SEx/CLx/CLV flag ops, loads P
//                from a pulled stack byte, forms the push byte and drives a
//                delayed IRQ mask to the interrupt logic.
//                Optional feature macro: DECIMAL_MODE_EN (stored D flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module status_register #(
  parameter logic [7:0] RESET_P   = 8'h24,
  parameter int         IRQ_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       ld_nz,
  input  logic       ld_c,
  input  logic       ld_v,
  input  logic [2:0] flag_op,
  input  logic       pull_ld,
  input  logic [7:0] pull_data,
  input  logic       set_i,
  input  logic       push_brk,
  input  logic       instr_done,
  output logic [7:0] p,
  output logic [7:0] push_byte,
  output logic       carry,
  output logic       overflow,
  output logic       decimal,
  output logic       irq_mask
);

  localparam logic [2:0] c_OP_CLC = 3'd1;
  localparam logic [2:0] c_OP_SEC = 3'd2;
  localparam logic [2:0] c_OP_CLI = 3'd3;
  localparam logic [2:0] c_OP_SEI = 3'd4;
  localparam logic [2:0] c_OP_CLD = 3'd5;
  localparam logic [2:0] c_OP_SED = 3'd6;
  localparam logic [2:0] c_OP_CLV = 3'd7;

  logic r_n, r_v, r_i, r_z, r_c;
  logic w_n_nxt, w_v_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
  logic w_d;
  logic w_unused_pull;

`ifdef DECIMAL_MODE_EN
  logic r_d;
  logic w_d_nxt;
  assign w_d           = r_d;
  assign w_unused_pull = ^pull_data[5:4];
`else
  assign w_d           = 1'b0;
  assign w_unused_pull = ^pull_data[5:3];
`endif

  // Next-state flags: later assignments override earlier ones, so the
  // statement order encodes priority pull_ld > set_i > flag_op > ld_*.
  always_comb begin
    w_n_nxt = r_n;
    w_v_nxt = r_v;
    w_i_nxt = r_i;
    w_z_nxt = r_z;
    w_c_nxt = r_c;
`ifdef DECIMAL_MODE_EN
    w_d_nxt = r_d;
`endif
    if (ld_nz) begin
      w_n_nxt = alu_n;
      w_z_nxt = alu_z;
    end
    if (ld_c) w_c_nxt = alu_c;
    if (ld_v) w_v_nxt = alu_v;
    case (flag_op)
      c_OP_CLC: w_c_nxt = 1'b0;
      c_OP_SEC: w_c_nxt = 1'b1;
      c_OP_CLI: w_i_nxt = 1'b0;
      c_OP_SEI: w_i_nxt = 1'b1;
`ifdef DECIMAL_MODE_EN
      c_OP_CLD: w_d_nxt = 1'b0;
      c_OP_SED: w_d_nxt = 1'b1;
`else
      c_OP_CLD, c_OP_SED: ;
`endif
      c_OP_CLV: w_v_nxt = 1'b0;
      default:  ;
    endcase
    if (set_i) w_i_nxt = 1'b1;
    if (pull_ld) begin
      w_n_nxt = pull_data[7];
      w_v_nxt = pull_data[6];
      w_i_nxt = pull_data[2];
      w_z_nxt = pull_data[1];
      w_c_nxt = pull_data[0];
`ifdef DECIMAL_MODE_EN
      w_d_nxt = pull_data[3];
`endif
    end
  end

  // Flag storage; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n <= RESET_P[7];
      r_v <= RESET_P[6];
      r_i <= RESET_P[2];
      r_z <= RESET_P[1];
      r_c <= RESET_P[0];
    end else begin
      r_n <= w_n_nxt;
      r_v <= w_v_nxt;
      r_i <= w_i_nxt;
      r_z <= w_z_nxt;
      r_c <= w_c_nxt;
    end
  end

`ifdef DECIMAL_MODE_EN
  // Decimal flag storage.
  always_ff @(posedge clk) begin
    if (rst) r_d <= RESET_P[3];
    else     r_d <= w_d_nxt;
  end
`endif

  // Bit 5 is hard-wired to 1 and B never exists in stored P.
  assign p         = {r_n, r_v, 1'b1, 1'b0,     w_d, r_i, r_z, r_c};
  assign push_byte = {r_n, r_v, 1'b1, push_brk, w_d, r_i, r_z, r_c};
  assign carry     = r_c;
  assign overflow  = r_v;
  assign decimal   = w_d;

  // IRQ mask pipeline, advancing only at instruction boundaries so that the
  // instruction following an I change still runs under the previous mask.
  generate
    if (IRQ_DELAY == 0) begin : g_irq_direct
      logic w_unused_idone;
      assign w_unused_idone = instr_done;
      assign irq_mask       = r_i;
    end else begin : g_irq_pipe
      logic [IRQ_DELAY-1:0] r_stage;
      // Shift registered I into the pipeline on each instr_done strobe;
      // r_i here is the pre-write value when a write coincides.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_stage <= {IRQ_DELAY{RESET_P[2]}};
        end else if (instr_done) begin
          r_stage[0] <= r_i;
          for (int k = 1; k < IRQ_DELAY; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end
      assign irq_mask = r_stage[IRQ_DELAY-1];
    end
  endgenerate

endmodule
`default_nettype wire
